// File: rtl/i2c_target_resp.sv
// I2C target responder: START/STOP decode, 7-bit address match,
// host-side byte interface for writes and reads, no clock stretching.
module i2c_target_resp #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h22,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       rx_first_o,
    input  logic       rx_ready_i,
    output logic       tx_req_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_underrun_o,
    output logic       busy_o,
    output logic       stop_o
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic scl_s, sda_s, scl_q, sda_q;
    logic scl_rise, scl_fall, start_det, stop_det;

    state_t state, state_n;
    logic [2:0] cnt, cnt_n;
    logic [7:0] shreg, shreg_n, rx_data, rx_data_n;
    logic [7:0] tx_sh, tx_sh_n, tx_lat, tx_lat_n;
    logic tx_have, tx_have_n, tx_pend, tx_pend_n;
    logic first, first_n, ack_drv, ack_drv_n;
    logic byte_done, byte_done_n, need_load, need_load_n;
    logic rd, rd_n, busy, busy_n, sda, sda_n;
    logic rx_valid, rx_valid_n, rx_first, rx_first_n;
    logic tx_req, tx_req_n, underrun, underrun_n, stop, stop_n;
    logic [7:0] ld_byte;
    logic ld_under;

    // Bus idles high, so the synchronizers reset to 1.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_q    <= scl_s;
            sda_q    <= sda_s;
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_q;
    assign scl_fall  = ~scl_s & scl_q;
    assign start_det = scl_s & scl_q & sda_q & ~sda_s;
    assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

    // Byte to put on the bus when the MSB slot opens; 8'hFF if the host missed it.
    assign ld_under = ~tx_have & ~(tx_pend & tx_valid_i);
    assign ld_byte  = tx_have ? tx_lat :
                      (tx_pend & tx_valid_i) ? tx_data_i : 8'hFF;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            cnt       <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            tx_sh     <= '0;
            tx_lat    <= '0;
            tx_have   <= 1'b0;
            tx_pend   <= 1'b0;
            first     <= 1'b0;
            ack_drv   <= 1'b0;
            byte_done <= 1'b0;
            need_load <= 1'b0;
            rd        <= 1'b0;
            busy      <= 1'b0;
            sda       <= 1'b1;
            rx_valid  <= 1'b0;
            rx_first  <= 1'b0;
            tx_req    <= 1'b0;
            underrun  <= 1'b0;
            stop      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            shreg     <= shreg_n;
            rx_data   <= rx_data_n;
            tx_sh     <= tx_sh_n;
            tx_lat    <= tx_lat_n;
            tx_have   <= tx_have_n;
            tx_pend   <= tx_pend_n;
            first     <= first_n;
            ack_drv   <= ack_drv_n;
            byte_done <= byte_done_n;
            need_load <= need_load_n;
            rd        <= rd_n;
            busy      <= busy_n;
            sda       <= sda_n;
            rx_valid  <= rx_valid_n;
            rx_first  <= rx_first_n;
            tx_req    <= tx_req_n;
            underrun  <= underrun_n;
            stop      <= stop_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        shreg_n     = shreg;
        rx_data_n   = rx_data;
        tx_sh_n     = tx_sh;
        tx_lat_n    = tx_lat;
        tx_have_n   = tx_have;
        tx_pend_n   = tx_pend;
        first_n     = first;
        ack_drv_n   = ack_drv;
        byte_done_n = byte_done;
        need_load_n = need_load;
        rd_n        = rd;
        busy_n      = busy;
        sda_n       = sda;
        rx_valid_n  = 1'b0;
        rx_first_n  = 1'b0;
        tx_req_n    = 1'b0;
        underrun_n  = 1'b0;
        stop_n      = 1'b0;

        if (tx_pend && tx_valid_i) begin
            tx_lat_n  = tx_data_i;
            tx_have_n = 1'b1;
            tx_pend_n = 1'b0;
        end

        if (start_det) begin
            state_n     = ADDR;
            cnt_n       = '0;
            sda_n       = 1'b1;
            ack_drv_n   = 1'b0;
            byte_done_n = 1'b0;
            need_load_n = 1'b0;
            tx_pend_n   = 1'b0;
            tx_have_n   = 1'b0;
        end else if (stop_det) begin
            state_n   = IDLE;
            sda_n     = 1'b1;
            stop_n    = busy;
            busy_n    = 1'b0;
            tx_pend_n = 1'b0;
            tx_have_n = 1'b0;
        end else begin
            unique case (state)
                IDLE: ;
                ADDR: begin
                    if (scl_rise) begin
                        shreg_n = {shreg[6:0], sda_s};
                        cnt_n   = 3'(cnt + 3'd1);
                        if (cnt == 3'd7) begin
                            if (shreg[6:0] == SLAVE_ADDR) begin
                                state_n   = ADDR_ACK;
                                busy_n    = 1'b1;
                                rd_n      = sda_s;
                                ack_drv_n = 1'b0;
                                if (sda_s) begin
                                    tx_req_n  = 1'b1;
                                    tx_pend_n = 1'b1;
                                    tx_have_n = 1'b0;
                                end
                            end else begin
                                state_n = IGNORE;
                                busy_n  = 1'b0;
                            end
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_drv) begin
                            sda_n     = 1'b0;
                            ack_drv_n = 1'b1;
                        end else begin
                            ack_drv_n = 1'b0;
                            cnt_n     = '0;
                            if (rd) begin
                                state_n     = RD_DATA;
                                sda_n       = ld_byte[7];
                                tx_sh_n     = {ld_byte[6:0], 1'b0};
                                underrun_n  = ld_under;
                                tx_have_n   = 1'b0;
                                tx_pend_n   = 1'b0;
                                need_load_n = 1'b0;
                            end else begin
                                state_n     = WR_DATA;
                                sda_n       = 1'b1;
                                first_n     = 1'b1;
                                byte_done_n = 1'b0;
                            end
                        end
                    end
                end
                WR_DATA: begin
                    if (scl_rise && !byte_done) begin
                        shreg_n = {shreg[6:0], sda_s};
                        cnt_n   = 3'(cnt + 3'd1);
                        if (cnt == 3'd7) begin
                            rx_data_n   = {shreg[6:0], sda_s};
                            byte_done_n = 1'b1;
                        end
                    end else if (scl_fall && byte_done) begin
                        if (rx_ready_i) begin
                            sda_n      = 1'b0;
                            rx_valid_n = 1'b1;
                            rx_first_n = first;
                        end
                        first_n     = 1'b0;
                        byte_done_n = 1'b0;
                        state_n     = WR_ACK;
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        sda_n   = 1'b1;
                        cnt_n   = '0;
                        state_n = WR_DATA;
                    end
                end
                RD_DATA: begin
                    if (scl_fall) begin
                        if (need_load) begin
                            sda_n       = ld_byte[7];
                            tx_sh_n     = {ld_byte[6:0], 1'b0};
                            underrun_n  = ld_under;
                            tx_have_n   = 1'b0;
                            tx_pend_n   = 1'b0;
                            need_load_n = 1'b0;
                            cnt_n       = '0;
                        end else if (cnt == 3'd7) begin
                            sda_n   = 1'b1;
                            state_n = RD_ACK;
                        end else begin
                            sda_n   = tx_sh[7];
                            tx_sh_n = {tx_sh[6:0], 1'b0};
                            cnt_n   = 3'(cnt + 3'd1);
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            state_n     = RD_DATA;
                            need_load_n = 1'b1;
                            tx_req_n    = 1'b1;
                            tx_pend_n   = 1'b1;
                            tx_have_n   = 1'b0;
                        end else begin
                            state_n = IGNORE;
                        end
                    end
                end
                IGNORE: ;
                default: state_n = IDLE;
            endcase
        end
    end

    assign sda_o         = sda;
    assign rx_data_o     = rx_data;
    assign rx_valid_o    = rx_valid;
    assign rx_first_o    = rx_first;
    assign tx_req_o      = tx_req;
    assign tx_underrun_o = underrun;
    assign busy_o        = busy;
    assign stop_o        = stop;

endmodule
